// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: sequential word fetch, pending-PC tracking,
// {pc, instr} queue toward execute, redirect flush with stale-response drop.
module fetch_queue_unit #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int unsigned QAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Fetch address and flow-control state
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [QAW:0]   count_q, count_d;
    logic [QAW-1:0] wr_ptr_q, wr_ptr_d;
    logic [QAW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCW-1:0] outst_q, outst_d;
    logic [OCW-1:0] drop_q, drop_d;
    logic [OAW-1:0] pw_q, pw_d;
    logic [OAW-1:0] pr_q, pr_d;

    // Storage
    logic [31:0] q_pc    [DEPTH];
    logic [31:0] q_instr [DEPTH];
    logic [31:0] pend_pc [MAX_OUTSTANDING];

    logic        credit_ok;
    logic        room_ok;
    logic        req_fire;
    logic        rsp_fire;
    logic        push;
    logic        pop;
    logic [31:0] pend_head;

    function automatic logic [OAW-1:0] pend_next(input logic [OAW-1:0] p);
        if (p == OAW'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + OAW'(1);
    endfunction

    // Request credit: every issued fetch must be guaranteed a queue slot
    always_comb begin
        credit_ok = (32'(count_q) + 32'(outst_q)) < DEPTH;
        room_ok   = 32'(outst_q) < MAX_OUTSTANDING;
    end

    // Handshake decode and combinational outputs
    always_comb begin
        imem_req_valid = !reset && !redirect_valid && room_ok && credit_ok;
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_fire       = imem_rsp_valid && !reset;
        pend_head      = pend_pc[pr_q];
        push           = rsp_fire && (drop_q == '0) && !redirect_valid;
        if_valid       = !reset && (count_q != '0) && !redirect_valid;
        pop            = if_valid && if_ready;
        if_pc          = 32'h0;
        if_instr       = NOP;
        if (if_valid) begin
            if_pc    = q_pc[rd_ptr_q];
            if_instr = q_instr[rd_ptr_q];
        end
    end

    // Next-state for fetch address, outstanding and drop counters
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        pw_d       = pw_q;
        pr_d       = pr_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'h3;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (req_fire) begin
            pw_d = pend_next(pw_q);
        end
        if (rsp_fire) begin
            pr_d = pend_next(pr_q);
        end

        unique case ({req_fire, rsp_fire})
            2'b10:   outst_d = outst_q + OCW'(1);
            2'b01:   outst_d = outst_q - OCW'(1);
            default: outst_d = outst_q;
        endcase

        if (redirect_valid) begin
            drop_d = outst_q - OCW'(rsp_fire);
        end else if (rsp_fire && (drop_q != '0)) begin
            drop_d = drop_q - OCW'(1);
        end
    end

    // Next-state for the instruction queue pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + QAW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + QAW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (QAW+1)'(1);
                2'b01:   count_d = count_q - (QAW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            pw_q       <= '0;
            pr_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            pw_q       <= pw_d;
            pr_q       <= pr_d;
        end
    end

    // Pending-PC slot written on every accepted request
    always_ff @(posedge clk) begin
        if (!reset && req_fire) begin
            pend_pc[pw_q] <= fetch_pc_q;
        end
    end

    // Queue slot written on every kept response
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            q_pc[wr_ptr_q]    <= pend_head;
            q_instr[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a latency-configurable
// in-order instruction memory model.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mem_lat = 1;
    int          due_q  [$];
    logic [31:0] addr_q [$];

    fetch_queue_unit #(
        .DEPTH(4),
        .MAX_OUTSTANDING(2),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_pc(if_pc),
        .if_instr(if_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // In-order memory: accepted request answered mem_lat cycles later
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            due_q.delete();
            addr_q.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            due_q.push_back(cyc + mem_lat - 1);
            addr_q.push_back(imem_req_addr);
        end
        #1;
        if (due_q.size() != 0 && due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memw(addr_q[0]);
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic out_chk(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(if_valid), 32'(v));
        if (v) begin
            chk({tag, "_pc"}, if_pc, pc);
            chk({tag, "_instr"}, if_instr, memw(pc));
        end else begin
            chk({tag, "_pc"}, if_pc, 32'h0);
            chk({tag, "_instr"}, if_instr, 32'h0000_0013);
        end
    endtask

    task automatic req_chk(input string tag, input logic v, input logic [31:0] a);
        chk({tag, "_reqv"}, 32'(imem_req_valid), 32'(v));
        if (v) begin
            chk({tag, "_addr"}, imem_req_addr, a);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset(input int lat, input logic rq, input logic ir);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_lat        = lat;
        imem_req_ready = rq;
        if_ready       = ir;
        nxt();
        nxt();
        reset = 1'b0;
    endtask

    initial begin
        // Reset values and zero-wait streaming
        reset = 1'b1;
        nxt();
        smp();
        req_chk("rst", 1'b0, 32'h0);
        out_chk("rst", 1'b0, 32'h0);
        nxt();
        reset = 1'b0;
        smp();
        req_chk("s1_c1", 1'b1, 32'h0);
        out_chk("s1_c1", 1'b0, 32'h0);
        nxt();
        smp();
        req_chk("s1_c2", 1'b1, 32'h4);
        out_chk("s1_c2", 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            nxt();
            smp();
            out_chk($sformatf("s1_pc%0d", k), 1'b1, 32'(4 * k));
        end

        // Backpressure fills the queue, then drains in order
        do_reset(1, 1'b1, 1'b0);
        repeat (10) nxt();
        smp();
        req_chk("s2_full", 1'b0, 32'h0);
        out_chk("s2_full", 1'b1, 32'h0);
        nxt();
        if_ready = 1'b1;
        smp();
        out_chk("s2_d0", 1'b1, 32'h0);
        for (int k = 1; k < 5; k++) begin
            nxt();
            smp();
            out_chk($sformatf("s2_d%0d", k), 1'b1, 32'(4 * k));
        end

        // Redirect with two slow responses in flight
        do_reset(3, 1'b1, 1'b1);
        smp();
        req_chk("s3_c1", 1'b1, 32'h0);
        nxt();
        smp();
        req_chk("s3_c2", 1'b1, 32'h4);
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        smp();
        req_chk("s3_redir", 1'b0, 32'h0);
        out_chk("s3_redir", 1'b0, 32'h0);
        nxt();
        redirect_valid = 1'b0;
        smp();
        req_chk("s3_c4", 1'b0, 32'h0);
        out_chk("s3_c4", 1'b0, 32'h0);
        nxt();
        smp();
        req_chk("s3_c5", 1'b1, 32'h100);
        out_chk("s3_c5", 1'b0, 32'h0);
        for (int k = 6; k < 9; k++) begin
            nxt();
            smp();
            out_chk($sformatf("s3_c%0d", k), 1'b0, 32'h0);
        end
        nxt();
        smp();
        out_chk("s3_t0", 1'b1, 32'h100);
        nxt();
        smp();
        out_chk("s3_t1", 1'b1, 32'h104);

        // Redirect coinciding with a response and a ready consumer
        do_reset(1, 1'b1, 1'b1);
        nxt();
        nxt();
        smp();
        out_chk("s4_c3", 1'b1, 32'h0);
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        smp();
        out_chk("s4_redir", 1'b0, 32'h0);
        req_chk("s4_redir", 1'b0, 32'h0);
        nxt();
        redirect_valid = 1'b0;
        smp();
        out_chk("s4_c5", 1'b0, 32'h0);
        req_chk("s4_c5", 1'b1, 32'h300);
        nxt();
        smp();
        out_chk("s4_c6", 1'b0, 32'h0);
        nxt();
        smp();
        out_chk("s4_t0", 1'b1, 32'h300);
        nxt();
        smp();
        out_chk("s4_t1", 1'b1, 32'h304);

        // Unaligned target, then back-to-back redirects
        do_reset(1, 1'b0, 1'b1);
        smp();
        req_chk("s5_c1", 1'b1, 32'h0);
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        smp();
        req_chk("s5_redir", 1'b0, 32'h0);
        nxt();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        smp();
        req_chk("s5_align", 1'b1, 32'h200);
        nxt();
        smp();
        req_chk("s5_c4", 1'b1, 32'h204);
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        smp();
        out_chk("s5_r40", 1'b0, 32'h0);
        nxt();
        redirect_pc = 32'h80;
        smp();
        out_chk("s5_r80", 1'b0, 32'h0);
        nxt();
        redirect_valid = 1'b0;
        smp();
        req_chk("s5_c7", 1'b1, 32'h80);
        out_chk("s5_c7", 1'b0, 32'h0);
        nxt();
        smp();
        out_chk("s5_c8", 1'b0, 32'h0);
        nxt();
        smp();
        out_chk("s5_t0", 1'b1, 32'h80);
        nxt();
        smp();
        out_chk("s5_t1", 1'b1, 32'h84);

        // Address wrap, then reset mid-stream
        do_reset(1, 1'b0, 1'b1);
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        nxt();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        smp();
        req_chk("s6_top", 1'b1, 32'hFFFF_FFFC);
        nxt();
        smp();
        req_chk("s6_wrap", 1'b1, 32'h0);
        nxt();
        smp();
        out_chk("s6_o0", 1'b1, 32'hFFFF_FFFC);
        nxt();
        smp();
        out_chk("s6_o1", 1'b1, 32'h0);
        nxt();
        reset = 1'b1;
        smp();
        req_chk("s6_rst", 1'b0, 32'h0);
        out_chk("s6_rst", 1'b0, 32'h0);
        nxt();
        reset = 1'b0;
        smp();
        req_chk("s6_re1", 1'b1, 32'h0);
        out_chk("s6_re1", 1'b0, 32'h0);
        nxt();
        smp();
        out_chk("s6_re2", 1'b0, 32'h0);
        nxt();
        smp();
        out_chk("s6_re3", 1'b1, 32'h0);
        nxt();
        smp();
        out_chk("s6_re4", 1'b1, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the execute/writeback datapath.
- Issues sequential word fetches to a variable-latency instruction memory and buffers {pc, instr} pairs in a small queue.
- Presents one instruction per cycle to the execute stage over a valid/ready handshake.
- On a taken branch (redirect), flushes the queue, discards stale in-flight responses, and restarts fetch at the target.

Parameters:
- DEPTH, 4: queue entries; must be a power of 2, at least 2.
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered imem requests; must be at least 1.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response data valid; in order, no backpressure.
- imem_rsp_data  input  32  fetched instruction.
- redirect_valid  input  1  one-cycle pulse: branch taken in execute.
- redirect_pc  input  32  branch target.
- if_valid  output  1  head entry valid for execute.
- if_ready  input  1  execute consumes head this cycle.
- if_pc  output  32  PC of head entry.
- if_instr  output  32  instruction of head entry.

Behaviour:
- Reset (sync, active-high):
  - fetch_pc <= RESET_PC; queue count, outstanding and drop_cnt <= 0.
  - Outputs during and after the reset cycle: imem_req_valid=0, if_valid=0, if_pc=0, if_instr=32'h00000013.
  - Reset mid-operation aborts everything; responses in flight across reset are out of contract (imem shares the same reset).
- Request issue:
  - imem_req_valid = !redirect_valid && outstanding < MAX_OUTSTANDING && (count + outstanding) < DEPTH. This credit rule guarantees queue space for every response.
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (wraps mod 2^32), the address is pushed into the pending-PC FIFO (MAX_OUTSTANDING entries), and outstanding is incremented.
- Response:
  - Each imem_rsp_valid pops the pending-PC FIFO and decrements outstanding. Minimum latency from request to response is 1 cycle.
  - If drop_cnt == 0 and no redirect this cycle: push {pending pc, imem_rsp_data} into the queue.
  - Otherwise: discard the response and decrement drop_cnt if it is nonzero.
- Output:
  - if_valid = (count != 0) && !redirect_valid.
  - if_pc/if_instr = head entry. When if_valid=0: if_pc=0 and if_instr=32'h00000013 (NOP).
  - Pop on if_valid && if_ready.
  - Simultaneous push and pop leaves count unchanged; push at count==DEPTH-1 with pop is legal.
- Redirect (redirect_valid=1), effects at the next edge:
  - Queue flushed (count=0, pointers reset); no pop is performed in this cycle.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; low bits are forced to 0.
  - drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0); the pending-PC FIFO keeps its entries so stale responses still pop it.
  - No request is issued in the redirect cycle.
  - New requests may issue the following cycle, including while drop_cnt > 0. Because responses are in order, the first drop_cnt responses are stale.
  - Back-to-back redirects: each recomputes drop_cnt from the current outstanding count; the last target wins.
- Latency, zero-wait memory (ready=1, response 1 cycle after accept):
  - First instruction becomes valid at the output 2 cycles after reset deassertion.
  - First post-redirect instruction becomes valid 2 cycles after the redirect cycle.
  - Sustained throughput is 1 instruction/cycle.
- Invariants (bench assertions):
  - count <= DEPTH; outstanding <= MAX_OUTSTANDING; drop_cnt <= outstanding.
  - imem_rsp_valid with outstanding==0 is illegal.

Test Plan:
- Reset, then ready=1, 1-cycle memory, if_ready=1 -> if_pc sequence 0,4,8,12 on consecutive cycles starting 2 cycles after reset release; if_instr matches memory words.
- if_ready=0 for 10 cycles -> queue fills to 4 entries, imem_req_valid drops to 0 once count+outstanding=4; releasing if_ready yields PCs 0..12 in order, then 16 with no gap or duplicate.
- Memory with 3-cycle latency and 2 outstanding requests, redirect_valid to 0x100 while both are in flight -> both stale responses are discarded, the queue stays empty, and the next if_pc=0x100 with the correct instruction.
- Redirect in the same cycle as imem_rsp_valid and if_ready=1 -> the response is dropped, no pop occurs, drop_cnt = outstanding-1, and the next output is the target PC.
- Redirect to 0x203 -> fetch address 0x200. Redirect on consecutive cycles to 0x40 then 0x80 -> only the 0x80 stream appears.
- Fetch from 0xFFFF_FFFC -> next address wraps to 0x0000_0000. Assert reset mid-stream -> outputs return to reset values at the next edge, and fetch restarts at RESET_PC.
